mc_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the npc core: replaces the fixed single-cycle issue with a state machine that fetches each instruction over a valid/ack handshake, decodes its class, optionally performs one data-memory access, then retires it with one-cycle write-enable pulses. It sits between the IFU/LSU memory ports and the datapath (PC, register file, ALU operand muxes). It also provides an ebreak halt, illegal-opcode trapping, a memory-wait watchdog and cycle/instret counters.

---
 rtl/mc_ctrl_fsm_if.sv | 32 +++
 rtl/mc_ctrl_fsm.sv | 152 +++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between the npc control sequencer and
// its memory ports, PC and register file.
interface mc_ctrl_fsm_if #(
  parameter int CNT_W = 64
);
  logic             ifu_req;
  logic             ifu_ack;
  logic [31:0]      inst;
  logic             lsu_req;
  logic             lsu_ack;
  logic             lsu_we;
  logic [31:0]      inst_q;
  logic             pc_we;
  logic             rf_we;
  logic             halt;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    output ifu_req, lsu_req, lsu_we, inst_q, pc_we, rf_we,
           halt, err, err_code, cycle_cnt, instret_cnt,
    input  ifu_ack, inst, lsu_ack
  );

  modport slave (
    input  ifu_req, lsu_req, lsu_we, inst_q, pc_we, rf_we,
           halt, err, err_code, cycle_cnt, instret_cnt,
    output ifu_ack, inst, lsu_ack
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle issue sequencer: fetch, decode, optional data access, retire.
// Adds ebreak halt, illegal-opcode trap, memory watchdog and perf counters.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 64,
  parameter int TMO_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  mc_ctrl_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_e;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
  localparam logic [31:0] EBREAK    = 32'h00100073;

  localparam bit             WD_EN  = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] WD_LIM = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: legal_op = 1'b1;
      default:                                      legal_op = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
      default:                                              writes_rd = 1'b0;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      inst_q;
  logic [TMO_W-1:0] wd_q;
  logic             ebreak_q;
  logic             ifu_req_q, lsu_req_q, lsu_we_q, pc_we_q, rf_we_q;
  logic             halt_q, err_q;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic [6:0]       opc;
  logic             wd_expired;

  assign opc        = inst_q[6:0];
  assign wd_expired = WD_EN && (wd_q == WD_LIM);

  // An ack arriving on the watchdog's last cycle takes priority over the trap.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.ifu_ack)     state_d = S_DECODE;
        else if (wd_expired) begin
          state_d    = S_TRAP;
          err_code_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (legal_op(opc)) state_d = S_EXEC;
        else begin
          state_d    = S_TRAP;
          err_code_d = 2'b01;
        end
      end
      S_EXEC:   state_d = (opc == OP_LOAD || opc == OP_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.lsu_ack)     state_d = S_WB;
        else if (wd_expired) begin
          state_d    = S_TRAP;
          err_code_d = 2'b11;
        end
      end
      S_WB:     state_d = ebreak_q ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_q exactly
  // without any combinational input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inst_q     <= '0;
      wd_q       <= '0;
      ebreak_q   <= 1'b0;
      ifu_req_q  <= 1'b0;
      lsu_req_q  <= 1'b0;
      lsu_we_q   <= 1'b0;
      pc_we_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      cycle_q    <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;

      if (state_q == S_FETCH && bus.ifu_ack) inst_q <= bus.inst;
      if (state_q == S_EXEC) ebreak_q <= (inst_q == EBREAK);

      if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
        wd_q <= '0;
      else if ((state_q == S_FETCH && !bus.ifu_ack) ||
               (state_q == S_MEM   && !bus.lsu_ack))
        wd_q <= wd_q + 1'b1;

      ifu_req_q <= (state_d == S_FETCH);
      lsu_req_q <= (state_d == S_MEM);
      lsu_we_q  <= (state_d == S_MEM) && (opc == OP_STORE);
      pc_we_q   <= (state_d == S_WB);
      rf_we_q   <= (state_d == S_WB) && writes_rd(opc);
      halt_q    <= halt_q | (state_d == S_HALT);
      err_q     <= err_q  | (state_d == S_TRAP);

      if (state_q != S_HALT && state_q != S_TRAP) cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == S_WB) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.ifu_req     = ifu_req_q;
  assign bus.lsu_req     = lsu_req_q;
  assign bus.lsu_we      = lsu_we_q;
  assign bus.inst_q      = inst_q;
  assign bus.pc_we       = pc_we_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.halt        = halt_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm with a short watchdog (TIMEOUT=8).
module tb_mc_ctrl_fsm;
  localparam int CNT_W = 64;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LW   = 32'h0000a103;
  localparam logic [31:0] SW   = 32'h0020a023;
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam logic [31:0] BAD  = 32'h0000007f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  mc_ctrl_fsm_if #(.CNT_W(CNT_W)) bus();
  mc_ctrl_fsm #(.TIMEOUT(8), .CNT_W(CNT_W), .TMO_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0; bus.inst = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle_to_fetch();
    chk("idle_req", bus.ifu_req, 1'b0);
    tick();
    chk("fetch_req", bus.ifu_req, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] w);
    bus.inst = w; bus.ifu_ack = 1'b1;
    tick();
    bus.ifu_ack = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0; bus.inst = '0;
    #12;
    chk("rst_ifu_req", bus.ifu_req, 0);
    chk("rst_lsu_req", bus.lsu_req, 0);
    chk("rst_pc_we", bus.pc_we, 0);
    chk("rst_halt_err", {bus.halt, bus.err, bus.err_code}, 0);
    chk("rst_inst_q", bus.inst_q, 0);
    chk("rst_cycle", bus.cycle_cnt, 0);
    chk("rst_instret", bus.instret_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_to_fetch();
    chk("cycle_after_idle", bus.cycle_cnt, 1);

    // addi with immediate ack
    fetch(ADDI);
    chk("addi_inst_q", bus.inst_q, ADDI);
    chk("decode_no_req", bus.ifu_req, 0);
    tick();
    chk("exec_no_pc_we", bus.pc_we, 0);
    tick();
    chk("addi_wb", {bus.pc_we, bus.rf_we}, 2'b11);
    tick();
    chk("addi_pulse_end", {bus.pc_we, bus.rf_we}, 2'b00);
    chk("addi_instret", bus.instret_cnt, 1);
    chk("addi_cycle", bus.cycle_cnt, 5);

    // lw, lsu_ack on the 4th request cycle
    fetch(LW); tick(); tick();
    chk("lw_we", bus.lsu_we, 0);
    n = 0;
    for (int i = 0; i < 20 && bus.lsu_req; i++) begin
      n++;
      if (n == 4) bus.lsu_ack = 1'b1;
      tick();
    end
    bus.lsu_ack = 1'b0;
    chk("lw_req_cycles", n, 4);
    chk("lw_wb", {bus.pc_we, bus.rf_we}, 2'b11);
    tick();
    chk("lw_instret", bus.instret_cnt, 2);

    // sw
    fetch(SW); tick(); tick();
    chk("sw_req_we", {bus.lsu_req, bus.lsu_we}, 2'b11);
    bus.lsu_ack = 1'b1;
    tick();
    bus.lsu_ack = 1'b0;
    chk("sw_wb", {bus.pc_we, bus.rf_we}, 2'b10);
    tick();
    chk("sw_instret", bus.instret_cnt, 3);

    // fetch ack on the 8th (last allowed) wait cycle
    repeat (7) tick();
    chk("fetch_wait7_req", bus.ifu_req, 1);
    fetch(ADDI);
    chk("late_ack_no_err", {bus.err, bus.ifu_req}, 2'b00);
    tick(); tick();
    chk("late_ack_wb", bus.pc_we, 1);
    tick();

    // LSU watchdog
    fetch(LW); tick(); tick();
    n = 0;
    for (int i = 0; i < 20 && bus.lsu_req; i++) begin n++; tick(); end
    chk("lsu_tmo_cycles", n, 8);
    chk("lsu_tmo_err", {bus.err, bus.err_code}, 3'b111);

    // fetch watchdog
    do_reset();
    idle_to_fetch();
    n = 0;
    for (int i = 0; i < 20 && bus.ifu_req; i++) begin n++; tick(); end
    chk("ifu_tmo_cycles", n, 8);
    chk("ifu_tmo_err", {bus.err, bus.err_code}, 3'b110);

    // illegal opcode
    do_reset();
    idle_to_fetch();
    fetch(BAD);
    chk("bad_decode_err", bus.err, 0);
    tick();
    chk("bad_trap_err", {bus.err, bus.err_code}, 3'b101);
    chk("bad_trap_pc_we", bus.pc_we, 0);
    bad = 0;
    bus.ifu_ack = 1'b1; bus.lsu_ack = 1'b1;
    repeat (100) begin
      tick();
      if (bus.ifu_req || bus.lsu_req || bus.pc_we || bus.rf_we) bad++;
    end
    bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0;
    chk("trap_quiet", bad, 0);
    chk("trap_cycle_frozen", bus.cycle_cnt, 3);

    // ebreak
    do_reset();
    idle_to_fetch();
    fetch(EBRK); tick(); tick();
    chk("ebrk_wb", {bus.pc_we, bus.rf_we, bus.halt}, 3'b100);
    tick();
    chk("ebrk_halt", {bus.halt, bus.pc_we, bus.ifu_req}, 3'b100);
    repeat (5) tick();
    chk("ebrk_cycle_frozen", bus.cycle_cnt, 5);
    chk("ebrk_instret", bus.instret_cnt, 1);

    // async reset during an LSU wait
    do_reset();
    idle_to_fetch();
    fetch(LW); tick(); tick(); tick();
    chk("mid_mem_req", bus.lsu_req, 1);
    #2 rst = 1'b1; bus.lsu_ack = 1'b1;
    #1;
    chk("async_rst_lsu", {bus.lsu_req, bus.ifu_req, bus.lsu_we}, 0);
    chk("async_rst_inst_q", bus.inst_q, 0);
    chk("async_rst_cycle", bus.cycle_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_to_fetch();
    chk("stale_ack_ignored", bus.lsu_req, 0);
    bus.lsu_ack = 1'b0;
    fetch(ADDI); tick(); tick();
    chk("resume_wb", {bus.pc_we, bus.rf_we}, 2'b11);
    tick();
    chk("resume_instret", bus.instret_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
